fp_muldiv_seq: RTL

- Sequencer for the FP multiply/divide unit.
- Accepts one operation at a time over a valid/ready handshake.
- Drives the exponent stage enable/select (2-register exponent pipeline; sel=1 means subtract, i.e. divide), then runs the iterative mantissa engine for a fixed cycle count, then triggers normalisation.
- Presents the result with a valid/ready output handshake.
- Sits between the operand-issue logic and the mul/div datapath.

---
 rtl/fp_muldiv_seq_if.sv | 33 +++
 rtl/fp_muldiv_seq.sv | 92 +++++++++
 2 files changed

// File: rtl/fp_muldiv_seq_if.sv
// Handshake and control bundle between the FP mul/div sequencer, the operand
// issue logic and the mul/div datapath.
interface fp_muldiv_seq_if #(
  parameter int unsigned CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_div;
  logic             in_special;
  logic             exp_en;
  logic             exp_sel;
  logic             mant_start;
  logic             mant_en;
  logic [CNT_W-1:0] mant_cnt;
  logic             norm_en;
  logic             out_valid;
  logic             out_ready;
  logic             out_div;
  logic             out_special;
  logic             busy;

  modport master (
    output in_valid, in_div, in_special, out_ready,
    input  in_ready, exp_en, exp_sel, mant_start, mant_en, mant_cnt,
           norm_en, out_valid, out_div, out_special, busy
  );

  modport slave (
    input  in_valid, in_div, in_special, out_ready,
    output in_ready, exp_en, exp_sel, mant_start, mant_en, mant_cnt,
           norm_en, out_valid, out_div, out_special, busy
  );
endinterface

// File: rtl/fp_muldiv_seq.sv
// Sequencer for the FP multiply/divide unit: exponent stage, iterative
// mantissa engine, normalisation, then a held result handshake.
module fp_muldiv_seq #(
  parameter int unsigned MUL_CYCLES = 24,
  parameter int unsigned DIV_CYCLES = 26,
  parameter int unsigned CNT_W      = 5
) (
  input  logic         clk,
  input  logic         arst,
  fp_muldiv_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, EXP, MANT, NORM, DONE} state_t;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXP_LAST = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             div_q, div_n;
  logic             spec_q, spec_n;

  always_ff @(posedge clk) begin
    if (arst) begin
      state  <= IDLE;
      cnt    <= '0;
      div_q  <= 1'b0;
      spec_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      div_q  <= div_n;
      spec_q <= spec_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_q;
    spec_n  = spec_q;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_n = EXP;
          cnt_n   = '0;
          div_n   = bus.in_div;
          spec_n  = bus.in_special;
        end
      end
      EXP: begin
        if (cnt == EXP_LAST) begin
          cnt_n   = '0;
          state_n = spec_q ? NORM : MANT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      MANT: begin
        if (cnt == (div_q ? DIV_LAST : MUL_LAST)) begin
          cnt_n   = '0;
          state_n = NORM;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      NORM: state_n = DONE;
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // exp_sel holds for the whole operation because the exponent pipeline
  // result stays live until the normaliser has captured it.
  always_comb begin
    bus.in_ready    = (state == IDLE) && !arst;
    bus.exp_en      = (state == EXP);
    bus.exp_sel     = (state != IDLE) && div_q;
    bus.mant_en     = (state == MANT);
    bus.mant_start  = (state == MANT) && (cnt == '0);
    bus.mant_cnt    = (state == MANT) ? cnt : '0;
    bus.norm_en     = (state == NORM);
    bus.out_valid   = (state == DONE);
    bus.out_div     = (state == DONE) && div_q;
    bus.out_special = (state == DONE) && spec_q;
    bus.busy        = (state != IDLE);
  end

endmodule
